// File: rtl/maj_tree_pipe_if.sv
// Handshake, config and status bundle for maj_tree_pipe.
// Ports: in_* token input, cfg_* leaf mask load, out_* result and transfer count.
interface maj_tree_pipe_if #(
    parameter int WIDTH  = 1,
    parameter int LEVELS = 2,
    parameter int CNTW   = 16
);
    localparam int L = 3 ** LEVELS;

    logic                 in_valid;
    logic                 in_ready;
    logic [L*WIDTH-1:0]   in_data;
    logic [1:0]           in_mode;
    logic                 cfg_we;
    logic [L-1:0]         cfg_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CNTW-1:0]      out_count;

    modport master (
        output in_valid, in_data, in_mode, cfg_we, cfg_inv, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, cfg_we, cfg_inv, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/maj_tree_pipe.sv
// Pipelined ternary gate tree (MAJ3/AND3/OR3) over 3^LEVELS masked leaves.
// Ports: clk, rst (sync, active-high), bus (slave side of maj_tree_pipe_if).
module maj_tree_pipe #(
    parameter int WIDTH  = 1,
    parameter int LEVELS = 2,
    parameter int CNTW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    maj_tree_pipe_if.slave bus
);
    localparam int L     = 3 ** LEVELS;
    // Every stage is packed into one flat vector, stage 1 first, root last.
    localparam int NODES = (L - 1) / 2;
    localparam int TW    = NODES * WIDTH;

    // Node offset of stage k inside the flat stage vector.
    function automatic int stage_off(input int k);
        int s;
        s = 0;
        for (int j = 1; j < k; j++) begin
            s += 3 ** (LEVELS - j);
        end
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] gate3(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic [WIDTH-1:0] y;
        case (m)
            2'b01:   y = a & b & c;
            2'b10:   y = a | b | c;
            default: y = (a & b) | (a & c) | (b & c);
        endcase
        return y;
    endfunction

    logic [L-1:0]        r_inv;
    logic [TW-1:0]       r_tree;
    logic [LEVELS-1:0]   r_valid;
    logic [2*LEVELS-1:0] r_mode;
    logic [CNTW-1:0]     r_count;

    logic [L*WIDTH-1:0]  w_leaf;
    logic [TW-1:0]       w_tree_nxt;
    logic [LEVELS-1:0]   w_valid_nxt;
    logic [2*LEVELS-1:0] w_mode_nxt;
    logic                w_stall;
    logic                w_out_xfer;
    logic                w_unused_mode;

    assign w_stall    = r_valid[LEVELS-1] & ~bus.out_ready;
    assign w_out_xfer = r_valid[LEVELS-1] & bus.out_ready;

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_valid[LEVELS-1];
    assign bus.out_data  = r_tree[TW-1 -: WIDTH];
    assign bus.out_count = r_count;

    // The root stage mode is carried for completeness but feeds nothing.
    assign w_unused_mode = ^r_mode[2*LEVELS-1 -: 2];

    genvar gi, gk, gj;
    generate
        // Leaf inversion applies to every lane of that leaf.
        for (gi = 0; gi < L; gi++) begin : g_leaf
            assign w_leaf[gi*WIDTH +: WIDTH] =
                bus.in_data[gi*WIDTH +: WIDTH] ^ {WIDTH{r_inv[gi]}};
        end

        for (gk = 1; gk <= LEVELS; gk++) begin : g_stage
            localparam int NK  = 3 ** (LEVELS - gk);
            localparam int OFF = stage_off(gk) * WIDTH;

            logic [3*NK*WIDTH-1:0] w_src;
            logic [1:0]            w_mode;

            if (gk == 1) begin : g_first
                assign w_src          = w_leaf;
                assign w_mode         = bus.in_mode;
                assign w_valid_nxt[0] = bus.in_valid;
            end else begin : g_next
                localparam int POFF = stage_off(gk - 1) * WIDTH;
                assign w_src             = r_tree[POFF +: 3*NK*WIDTH];
                assign w_mode            = r_mode[2*(gk-2) +: 2];
                assign w_valid_nxt[gk-1] = r_valid[gk-2];
            end

            assign w_mode_nxt[2*(gk-1) +: 2] = w_mode;

            for (gj = 0; gj < NK; gj++) begin : g_node
                assign w_tree_nxt[OFF + gj*WIDTH +: WIDTH] = gate3(
                    w_mode,
                    w_src[(3*gj)*WIDTH   +: WIDTH],
                    w_src[(3*gj+1)*WIDTH +: WIDTH],
                    w_src[(3*gj+2)*WIDTH +: WIDTH]
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv   <= '0;
            r_tree  <= '0;
            r_valid <= '0;
            r_mode  <= '0;
            r_count <= '0;
        end else begin
            // Mask loads even while stalled; the accepting token sees the old mask.
            if (bus.cfg_we) begin
                r_inv <= bus.cfg_inv;
            end
            // Whole pipe freezes on stall, so nothing inside can be lost.
            if (!w_stall) begin
                r_tree  <= w_tree_nxt;
                r_valid <= w_valid_nxt;
                r_mode  <= w_mode_nxt;
            end
            if (w_out_xfer) begin
                r_count <= r_count + CNTW'(1);
            end
        end
    end
endmodule

// File: doc/maj_tree_pipe.md
MAJ_TREE_PIPE -- requirements
Module: maj_tree_pipe

Interface
REQ-001 Parameter WIDTH, 1: independent bit-slice lanes evaluated in parallel.
REQ-002 Parameter LEVELS, 2 (legal 1..6): tree depth; leaf count L = 3^LEVELS.
REQ-003 Parameter CNTW, 16: width of out_count.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input token present.
REQ-007 in_ready  out  1  block can accept a token this cycle.
REQ-008 in_data  in  L*WIDTH  leaf i, lane b at bit i*WIDTH+b.
REQ-009 in_mode  in  2  gate function for this token: 00 MAJ3, 01 AND3, 10 OR3, 11 MAJ3.
REQ-010 cfg_we  in  1  load cfg_inv into the leaf inversion mask.
REQ-011 cfg_inv  in  L  per-leaf invert bit (applies to all lanes of that leaf).
REQ-012 out_valid  out  1  result token present.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 out_data  out  WIDTH  root result per lane.
REQ-015 out_count  out  CNTW  number of completed output transfers, modulo 2^CNTW.

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 The datapath is LEVELS register stages; stage k (1..LEVELS) holds 3^(LEVELS-k) nodes x WIDTH bits plus a valid bit and the token's 2-bit mode.
REQ-018 Node j of stage k is computed from nodes 3j, 3j+1, 3j+2 of stage k-1 (stage 0 = masked leaves), per lane, bitwise.
REQ-019 Stage-0 leaf value = in_data leaf i XOR inv_mask[i], replicated across lanes.
REQ-020 Gate per mode: MAJ3 = ab|ac|bc; AND3 = a&b&c; OR3 = a|b|c; mode travels with its token and is applied at every level.
REQ-021 Latency: a token accepted in cycle t appears on out_valid/out_data in cycle t+LEVELS when no stall occurs.
REQ-022 Global stall = out_valid && !out_ready; while stalled, no stage register, valid bit, or mode changes.
REQ-023 in_ready = !stall (combinational); bubbles are not compressed.
REQ-024 When not stalled, stage 1 loads valid = in_valid and data/mode from the input; each later stage loads from its predecessor.
REQ-025 out_data and out_valid are driven directly from stage LEVELS registers; out_data holds stable while out_valid && !out_ready.
REQ-026 Sustained throughput is one token per cycle when out_ready is held high.
REQ-027 cfg_we updates inv_mask at the clock edge; a token accepted in the same cycle as cfg_we uses the old mask, and later tokens use the new one; tokens in flight are unaffected.
REQ-028 cfg_we is honoured during stall.
REQ-029 out_count increments by 1 on each output transfer and wraps from 2^CNTW-1 to 0.
REQ-030 When in_valid is low and no stall, stage 1 valid clears; data in invalid stages is don't-care but deterministic (still registered).

Reset
REQ-031 When rst is high at a clock edge, all stage valid bits, stage data, stage modes, inv_mask, and out_count become 0; out_valid=0, out_data=0.
REQ-032 rst overrides stall, cfg_we, and input transfer in the same cycle; in-flight tokens are discarded and not counted.
REQ-033 in_ready is 1 in the first cycle after reset.

Verification (WIDTH=1, LEVELS=2, L=9 unless stated)
REQ-034 After reset, mask 0, mode 00, in_data=9'b000_011_111, out_ready=1 -> out_valid=1, out_data=1 exactly 2 cycles later; out_count=1.
REQ-035 Same data with mode 01 -> out_data=0; with mode 10 -> out_data=1; with in_data=9'b000_000_111 in mode 00 -> out_data=0.
REQ-036 cfg_we with cfg_inv=9'h1FF in the same cycle as accepting 9'b000_011_111 (mode 00) -> output 1; the next token with the same data -> output 0.
REQ-037 Stream 5 tokens back-to-back, then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, no token is lost or duplicated, order is preserved, and out_count=5.
REQ-038 CNTW=4: 17 transfers -> out_count=1; rst asserted with 2 tokens in flight -> out_valid=0 the next cycle, and out_count=0.
REQ-039 WIDTH=4, LEVELS=1: lanes set to a=4'b1100, b=4'b1010, c=4'b0110, mode 00 -> out_data=4'b1110 after 1 cycle.
